// File: rtl/rv_mul_seq.sv
// Control sequencer for the byte-slice 32x32 multiplier: clears the product,
// walks the ten partial products that reach the low 32 bits, then pulses done.
module rv_mul_seq #(
    parameter int SEL_W   = 2,
    parameter int SHIFT_W = 5,
    parameter int PP_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic [SEL_W-1:0]   a_sel,
    output logic [SEL_W-1:0]   b_sel,
    output logic [SHIFT_W-1:0] shift_val,
    output logic               upd_prod,
    output logic               clr_prod,
    output logic               busy,
    output logic               done,
    output logic [3:0]         step
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLR,
        ST_ACC,
        ST_DONE
    } state_e;

    localparam logic [3:0] LAST_STEP = 4'd9;

    state_e     state_q, state_d;
    logic [3:0] step_q, step_d;
    int         aIdx, bIdx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            step_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = 4'd0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CLR;
            end
            ST_CLR: begin
                state_d = abort ? ST_IDLE : ST_ACC;
            end
            ST_ACC: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (step_q == LAST_STEP) begin
                    state_d = ST_DONE;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            ST_DONE: begin
                // start outranks abort here so back-to-back multiplies never stall
                state_d = start ? ST_CLR : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Byte pairs are issued in order of ascending weight a_sel+b_sel.
    always_comb begin
        aIdx = 0;
        bIdx = 0;
        case (step_q)
            4'd0: begin aIdx = 0; bIdx = 0; end
            4'd1: begin aIdx = 0; bIdx = 1; end
            4'd2: begin aIdx = 1; bIdx = 0; end
            4'd3: begin aIdx = 0; bIdx = 2; end
            4'd4: begin aIdx = 1; bIdx = 1; end
            4'd5: begin aIdx = 2; bIdx = 0; end
            4'd6: begin aIdx = 0; bIdx = 3; end
            4'd7: begin aIdx = 1; bIdx = 2; end
            4'd8: begin aIdx = 2; bIdx = 1; end
            4'd9: begin aIdx = 3; bIdx = 0; end
            default: begin aIdx = 0; bIdx = 0; end
        endcase
    end

    always_comb begin
        a_sel     = '0;
        b_sel     = '0;
        shift_val = '0;
        upd_prod  = 1'b0;
        clr_prod  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        step      = 4'd0;
        case (state_q)
            ST_CLR: begin
                clr_prod = 1'b1;
                busy     = 1'b1;
            end
            ST_ACC: begin
                upd_prod  = 1'b1;
                busy      = 1'b1;
                step      = step_q;
                a_sel     = SEL_W'(aIdx);
                b_sel     = SEL_W'(bIdx);
                shift_val = SHIFT_W'(PP_W * (aIdx + bIdx));
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assert property (@(posedge clk) disable iff (rst) !(clr_prod && upd_prod));
    assert property (@(posedge clk) disable iff (rst) $onehot0({clr_prod, upd_prod, done}));

endmodule

// File: tb/tb_rv_mul_seq.sv
// Randomised bench for rv_mul_seq: a cycle-count sequence model plus a model of
// the byte-slice arithmetic unit whose accumulated product is checked against a*b.
module tb_rv_mul_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] a_sel, b_sel;
    logic [4:0] shift_val;
    logic       upd_prod, clr_prod, busy, done;
    logic [3:0] step;

    int          vectors = 0;
    int          miscompares = 0;
    int          cnt = 0;
    int          updRun = 0;
    int          tblA[$];
    int          tblB[$];
    logic [31:0] opA = 32'd0;
    logic [31:0] opB = 32'd0;
    logic [31:0] prodModel = 32'd0;
    logic [31:0] expProd;
    logic [16:0] obsVec;
    logic [16:0] expVec;

    rv_mul_seq dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .a_sel(a_sel), .b_sel(b_sel), .shift_val(shift_val),
        .upd_prod(upd_prod), .clr_prod(clr_prod), .busy(busy),
        .done(done), .step(step)
    );

    always #5 clk = ~clk;

    assign obsVec = {a_sel, b_sel, shift_val, upd_prod, clr_prod, busy, done, step};

    initial begin
        #3000000;
        $display("FAIL timeout vectors=%0d expected completion", vectors);
        $fatal(1, "[TB] timeout");
    end

    // Every byte pair whose weight lands below bit 32, by ascending weight.
    task automatic buildTable();
        for (int s = 0; s <= 3; s++)
            for (int a = 0; a <= s; a++) begin
                tblA.push_back(a);
                tblB.push_back(s - a);
            end
    endtask

    // cnt = cycles since the accepted start (0 = idle); 1 clear, 2..11 accumulate, 12 done.
    function automatic logic [16:0] expOut(int c);
        logic [1:0] ea = 2'd0, eb = 2'd0;
        logic [4:0] sh = 5'd0;
        logic       up = 1'b0, cl = 1'b0, bz = 1'b0, dn = 1'b0;
        logic [3:0] st = 4'd0;
        if (c == 1) begin
            cl = 1'b1; bz = 1'b1;
        end else if (c >= 2 && c <= 11) begin
            ea = 2'(tblA[c-2]);
            eb = 2'(tblB[c-2]);
            sh = 5'(8 * (tblA[c-2] + tblB[c-2]));
            up = 1'b1; bz = 1'b1;
            st = 4'(c - 2);
        end else if (c == 12) begin
            dn = 1'b1;
        end
        return {ea, eb, sh, up, cl, bz, dn, st};
    endfunction

    // Arithmetic-unit model update for the sampled cycle, then the clock edge.
    task automatic cycleEnd();
        logic [31:0] pp;
        if (clr_prod === 1'b1) begin
            prodModel = 32'd0;
        end else if (upd_prod === 1'b1) begin
            pp = ((opA >> (8 * a_sel)) & 32'hFF) * ((opB >> (8 * b_sel)) & 32'hFF);
            prodModel = prodModel + (pp << shift_val);
        end
        updRun = (upd_prod === 1'b1) ? updRun + 1 : 0;
        @(posedge clk);
        if (rst) cnt = 0;
        else if (cnt == 0) cnt = start ? 1 : 0;
        else if (cnt < 12) cnt = abort ? 0 : cnt + 1;
        else cnt = start ? 1 : 0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            cycleEnd();
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (obsVec !== 17'd0 || cnt != 0) begin
                miscompares++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obsVec, 17'd0);
            end
            cycleEnd();
        end
    endtask

    task automatic test_single();
        opA = 32'h12345678; opB = 32'h9ABCDEF0;
        for (int c = 0; c < 15; c++) begin
            start = (c == 0); abort = 1'b0;
            @(negedge clk);
            vectors++;
            expVec = expOut(cnt);
            if (obsVec !== expVec) begin
                miscompares++;
                $display("FAIL single_seq cyc=%0d got=%h exp=%h", c, obsVec, expVec);
            end
            if (cnt == 12) begin
                vectors++;
                expProd = opA * opB;
                if (prodModel !== expProd) begin
                    miscompares++;
                    $display("FAIL single_prod got=%h exp=%h", prodModel, expProd);
                end
            end
            cycleEnd();
        end
    endtask

    task automatic test_back_to_back();
        opA = 32'hFFFFFFFF; opB = 32'hFFFFFFFF;
        for (int c = 0; c < 28; c++) begin
            start = (c <= 12); abort = 1'b0;
            @(negedge clk);
            vectors++;
            expVec = expOut(cnt);
            if (obsVec !== expVec) begin
                miscompares++;
                $display("FAIL held_start cyc=%0d got=%h exp=%h", c, obsVec, expVec);
            end
            if (cnt == 12) begin
                vectors++;
                if (prodModel !== 32'h00000001) begin
                    miscompares++;
                    $display("FAIL held_prod cyc=%0d got=%h exp=%h", c, prodModel, 32'h1);
                end
            end
            cycleEnd();
        end
    endtask

    task automatic test_abort();
        opA = $urandom; opB = $urandom;
        for (int c = 0; c < 10; c++) begin
            start = (c == 0); abort = (c == 6);
            @(negedge clk);
            vectors++;
            expVec = expOut(cnt);
            if (obsVec !== expVec) begin
                miscompares++;
                $display("FAIL abort_seq cyc=%0d got=%h exp=%h", c, obsVec, expVec);
            end
            cycleEnd();
        end
        opA = 32'd7; opB = 32'd6;
        for (int c = 0; c < 14; c++) begin
            start = (c == 0); abort = 1'b0;
            @(negedge clk);
            vectors++;
            expVec = expOut(cnt);
            if (obsVec !== expVec) begin
                miscompares++;
                $display("FAIL after_abort cyc=%0d got=%h exp=%h", c, obsVec, expVec);
            end
            if (cnt == 12) begin
                vectors++;
                if (prodModel !== 32'd42) begin
                    miscompares++;
                    $display("FAIL after_abort_prod got=%0d exp=%0d", prodModel, 42);
                end
            end
            cycleEnd();
        end
    endtask

    task automatic test_reset_mid();
        opA = $urandom; opB = $urandom;
        for (int c = 0; c < 24; c++) begin
            start = (c == 0 || c == 8); abort = 1'b0;
            rst = (c == 4);
            @(negedge clk);
            vectors++;
            expVec = expOut(cnt);
            if (obsVec !== expVec) begin
                miscompares++;
                $display("FAIL reset_mid cyc=%0d got=%h exp=%h", c, obsVec, expVec);
            end
            if (cnt == 12) begin
                vectors++;
                expProd = opA * opB;
                if (prodModel !== expProd) begin
                    miscompares++;
                    $display("FAIL reset_mid_prod got=%h exp=%h", prodModel, expProd);
                end
            end
            cycleEnd();
        end
        rst = 1'b0;
    endtask

    task automatic test_stress();
        for (int c = 0; c < 2000; c++) begin
            if (cnt == 0) begin
                opA = $urandom; opB = $urandom;
            end
            start = ($urandom_range(3) == 0);
            abort = ($urandom_range(24) == 0);
            rst   = ($urandom_range(199) == 0);
            @(negedge clk);
            vectors++;
            expVec = expOut(cnt);
            if (obsVec !== expVec) begin
                miscompares++;
                $display("FAIL stress_seq cyc=%0d got=%h exp=%h", c, obsVec, expVec);
            end
            if ((clr_prod & upd_prod) !== 1'b0 || shift_val > 5'd24) begin
                miscompares++;
                $display("FAIL stress_inv cyc=%0d got clr=%b upd=%b sh=%0d exp exclusive, sh<=24",
                         c, clr_prod, upd_prod, shift_val);
            end
            if (done === 1'b1) begin
                vectors++;
                expProd = opA * opB;
                if (updRun != 10 || prodModel !== expProd) begin
                    miscompares++;
                    $display("FAIL stress_done cyc=%0d got run=%0d prod=%h exp run=10 prod=%h",
                             c, updRun, prodModel, expProd);
                end
            end
            cycleEnd();
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0;
    endtask

    initial begin
        buildTable();
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_stress();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
